// File: rtl/prod_arb_pkg.sv
// Shared types and default constants for the producer-side write arbiter.
package prod_arb_pkg;

  localparam int C_DATA_WIDTH = 8;
  localparam int C_NUM_REQ    = 4;
  localparam int C_BURST_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  // Width of a counter that must hold every value from 0 to burst_len.
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requesting index at or after
// the pointer, wrapping to index 0 when nothing at or above it requests.
module rr_pick #(
  parameter int P_NUM_REQ = 4,
  parameter int P_PTR_W   = 2
) (
  input  logic [P_NUM_REQ-1:0] i_req,
  input  logic [P_PTR_W-1:0]   i_ptr,
  output logic [P_NUM_REQ-1:0] o_pick,
  output logic                 o_valid
);

  logic [P_NUM_REQ-1:0] hi_s;
  logic [P_NUM_REQ-1:0] cand_s;
  logic [P_NUM_REQ-1:0] pick_s;
  logic                 seen_s;

  // Mask off requests below the pointer; fall back to the full vector on wrap.
  always_comb begin
    hi_s = {P_NUM_REQ{1'b0}};
    for (int i = 0; i < P_NUM_REQ; i++) begin
      hi_s[i] = i_req[i] & (P_PTR_W'(i) >= i_ptr);
    end
    cand_s = (|hi_s) ? hi_s : i_req;
  end

  // Keep only the lowest set bit of the candidate vector.
  always_comb begin
    pick_s = {P_NUM_REQ{1'b0}};
    seen_s = 1'b0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      pick_s[i] = cand_s[i] & ~seen_s;
      seen_s    = seen_s | cand_s[i];
    end
  end

  assign o_pick  = pick_s;
  assign o_valid = |i_req;

endmodule

// File: rtl/prod_wr_arbiter.sv
// Round-robin arbiter granting bursts of FIFO writes to one producer at a
// time. The write strobe and ack follow the owner's request with zero latency;
// the owner, pointer, count and state are held in flops.
module prod_wr_arbiter
  import prod_arb_pkg::*;
#(
  parameter int P_DATA_WIDTH = C_DATA_WIDTH,
  parameter int P_NUM_REQ    = C_NUM_REQ,
  parameter int P_BURST_LEN  = C_BURST_LEN
) (
  input  logic                              PROD_CLK,
  input  logic                              I_RST_N,
  input  logic [P_NUM_REQ-1:0]              I_REQ,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] I_REQ_DATA,
  input  logic                              I_FULL,
  output logic [P_NUM_REQ-1:0]              O_GNT,
  output logic [P_NUM_REQ-1:0]              O_ACK,
  output logic [P_DATA_WIDTH-1:0]           O_DATA,
  output logic                              O_WR_EN,
  output logic                              O_STALL
);

  localparam int PW = $clog2(P_NUM_REQ);
  localparam int CW = cnt_width(P_BURST_LEN);

  arb_state_e             state_q, state_d;
  logic [P_NUM_REQ-1:0]   owner_q, owner_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [P_NUM_REQ-1:0]   pick_s;
  logic                   pick_valid_s;
  logic [PW-1:0]          owner_idx_s;
  logic [PW-1:0]          ptr_next_s;
  logic [CW-1:0]          cnt_inc_s;
  logic                   own_req_s;
  logic                   wr_en_s;
  logic [P_NUM_REQ-1:0]   ack_s;
  logic [P_DATA_WIDTH-1:0] data_s;

  rr_pick #(
    .P_NUM_REQ (P_NUM_REQ),
    .P_PTR_W   (PW)
  ) u_rr_pick (
    .i_req   (I_REQ),
    .i_ptr   (ptr_q),
    .o_pick  (pick_s),
    .o_valid (pick_valid_s)
  );

  // Owner index and the pointer value to load when the burst ends.
  always_comb begin
    owner_idx_s = {PW{1'b0}};
    for (int i = 0; i < P_NUM_REQ; i++) begin
      owner_idx_s = owner_idx_s | (owner_q[i] ? PW'(i) : {PW{1'b0}});
    end
    ptr_next_s = (owner_idx_s == PW'(P_NUM_REQ - 1)) ? {PW{1'b0}}
                                                     : owner_idx_s + PW'(1);
  end

  // Route the owner's slice of the packed request data to the FIFO.
  always_comb begin
    data_s = {P_DATA_WIDTH{1'b0}};
    for (int i = 0; i < P_NUM_REQ; i++) begin
      data_s = data_s | (I_REQ_DATA[i*P_DATA_WIDTH +: P_DATA_WIDTH]
                         & {P_DATA_WIDTH{owner_q[i]}});
    end
  end

  assign own_req_s = |(I_REQ & owner_q);
  assign cnt_inc_s = cnt_q + CW'(1);

  // Next-state, burst bookkeeping and the same-cycle write/ack strobes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en_s = 1'b0;
    ack_s   = {P_NUM_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          owner_d = pick_s;
          cnt_d   = {CW{1'b0}};
          state_d = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!own_req_s) begin
          owner_d = {P_NUM_REQ{1'b0}};
          ptr_d   = ptr_next_s;
          state_d = IDLE;
        end else if (I_FULL) begin
          state_d = STALL;
        end else begin
          wr_en_s = 1'b1;
          ack_s   = owner_q;
          cnt_d   = cnt_inc_s;
          if (cnt_inc_s == CW'(P_BURST_LEN)) begin
            owner_d = {P_NUM_REQ{1'b0}};
            ptr_d   = ptr_next_s;
            state_d = IDLE;
          end else begin
            state_d = BURST;
          end
        end
      end
      STALL: begin
        if (!own_req_s) begin
          owner_d = {P_NUM_REQ{1'b0}};
          ptr_d   = ptr_next_s;
          state_d = IDLE;
        end else if (!I_FULL) begin
          state_d = BURST;
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        owner_d = {P_NUM_REQ{1'b0}};
        ptr_d   = {PW{1'b0}};
        cnt_d   = {CW{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge PROD_CLK) begin
    if (!I_RST_N) begin
      state_q <= IDLE;
      owner_q <= {P_NUM_REQ{1'b0}};
      ptr_q   <= {PW{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign O_GNT   = (state_q == IDLE) ? {P_NUM_REQ{1'b0}} : owner_q;
  assign O_STALL = (state_q == STALL);
  assign O_WR_EN = wr_en_s;
  assign O_ACK   = ack_s;
  assign O_DATA  = (state_q == IDLE) ? {P_DATA_WIDTH{1'b0}} : data_s;

endmodule

// File: tb/tb_prod_wr_arbiter.sv
// Directed bench for prod_wr_arbiter: per-cycle grant/write/stall expectations,
// a write scoreboard fed by the stimulus, and per-cycle protocol invariants.
module tb_prod_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  wdata;
  logic        wr_en;
  logic        stall;

  logic [7:0]  data_r [4];

  typedef struct {
    logic [3:0] ack;
    logic [7:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  assign req_data = {data_r[3], data_r[2], data_r[1], data_r[0]};

  prod_wr_arbiter dut (
    .PROD_CLK   (clk),
    .I_RST_N    (rst_n),
    .I_REQ      (req),
    .I_REQ_DATA (req_data),
    .I_FULL     (full),
    .O_GNT      (gnt),
    .O_ACK      (ack),
    .O_DATA     (wdata),
    .O_WR_EN    (wr_en),
    .O_STALL    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int r, input logic [7:0] start, input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.ack  = 4'b0001 << r;
      w.data = start + 8'(k);
      sb_q.push_back(w);
    end
  endtask

  // One clock cycle: sample at the falling edge, then step past the rising edge.
  task automatic tk(input logic [3:0] eg, input logic ew, input logic es, input bit chk);
    logic [3:0] ack_seen;
    wr_t        w;
    @(negedge clk);
    ack_seen = ack;
    check("gnt_onehot", 32'((gnt & (gnt - 4'd1)) == 4'd0), 32'd1);
    check("ack_onehot", 32'((ack & (ack - 4'd1)) == 4'd0), 32'd1);
    check("wr_while_full", 32'(wr_en & full), 32'd0);
    check("ack_non_owner", 32'(ack & ~gnt), 32'd0);
    if (chk) begin
      check("gnt", 32'(gnt), 32'(eg));
      check("wr_en", 32'(wr_en), 32'(ew));
      check("stall", 32'(stall), 32'(es));
      if (eg == 4'd0) begin
        check("idle_data", 32'(wdata), 32'd0);
      end
      if (wr_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = sb_q.pop_front();
          check("wr_ack", 32'(ack), 32'(w.ack));
          check("wr_data", 32'(wdata), 32'(w.data));
        end
      end else begin
        check("ack_without_wr", 32'(ack), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (ack_seen[i] && chk) data_r[i] = data_r[i] + 8'd1;
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    full  = 1'b0;
    for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
    @(posedge clk);
    #1;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    // Single requester: 4 writes, one idle cycle, re-grant.
    data_r[0] = 8'h11;
    req = 4'b0001;
    push_words(0, 8'h11, 6);
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) tk(4'b0001, 1'b1, 1'b0, 1'b1);
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) tk(4'b0001, 1'b1, 1'b0, 1'b1);
    req = 4'b0000;
    tk(4'b0001, 1'b0, 1'b0, 1'b1);
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    check("sb_empty_single", 32'(sb_q.size()), 32'd0);

    // All requesting: grant order 0,1,2,3,0 with 4 words each.
    rst_pulse();
    data_r[0] = 8'h30; data_r[1] = 8'h40; data_r[2] = 8'h50; data_r[3] = 8'h60;
    push_words(0, 8'h30, 4); push_words(1, 8'h40, 4);
    push_words(2, 8'h50, 4); push_words(3, 8'h60, 4);
    push_words(0, 8'h34, 4);
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      tk(4'b0000, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
        if (b == 4 && k == 3) begin
          tk(4'b0001 << (b % 4), 1'b1, 1'b0, 1'b1);
          req = 4'b0000;
        end else begin
          tk(4'b0001 << (b % 4), 1'b1, 1'b0, 1'b1);
        end
      end
    end
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    check("sb_empty_all", 32'(sb_q.size()), 32'd0);

    // Full stall for owner 2 after 2 words.
    rst_pulse();
    data_r[2] = 8'h70;
    push_words(2, 8'h70, 4);
    req = 4'b0100;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) tk(4'b0100, 1'b1, 1'b0, 1'b1);
    full = 1'b1;
    tk(4'b0100, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) tk(4'b0100, 1'b0, 1'b1, 1'b1);
    full = 1'b0;
    tk(4'b0100, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) tk(4'b0100, 1'b1, 1'b0, 1'b1);
    req = 4'b0000;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    check("sb_empty_stall", 32'(sb_q.size()), 32'd0);

    // Early drop by owner 1; pointer 2 must favour 3 over 0.
    rst_pulse();
    data_r[0] = 8'h01; data_r[1] = 8'h90; data_r[3] = 8'hB0;
    push_words(1, 8'h90, 2);
    push_words(3, 8'hB0, 4);
    req = 4'b1010;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) tk(4'b0010, 1'b1, 1'b0, 1'b1);
    req = 4'b1001;
    tk(4'b0010, 1'b0, 1'b0, 1'b1);
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) tk(4'b1000, 1'b1, 1'b0, 1'b1);
    tk(4'b1000, 1'b1, 1'b0, 1'b1);
    req = 4'b0000;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    check("sb_empty_drop", 32'(sb_q.size()), 32'd0);

    // Reset during owner 3's second word, then arbitration from pointer 0.
    rst_pulse();
    data_r[1] = 8'hD0; data_r[3] = 8'hC0;
    push_words(3, 8'hC0, 1);
    req = 4'b1000;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    tk(4'b1000, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    tk(4'b1000, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    req = 4'b1010;
    push_words(1, 8'hD0, 4);
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) tk(4'b0010, 1'b1, 1'b0, 1'b1);
    tk(4'b0010, 1'b1, 1'b0, 1'b1);
    req = 4'b0000;
    tk(4'b0000, 1'b0, 1'b0, 1'b1);
    check("sb_empty_reset", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
